// File: rtl/wrapper_risc_if.sv
// Display port of the RISC wrapper: the push-button select and the 16-bit view of r1.
interface wrapper_risc_if;
  logic        button;
  logic [15:0] out;

  modport master (output button, input  out);
  modport slave  (input  button, output out);
endinterface

// File: rtl/wrapper_risc.sv
// Single-cycle 32-bit KGP-style RISC core with a built-in 64-word program ROM,
// 64-word data RAM and 32x32 register file; r1 is shown on the display port.
module wrapper_risc (
  input  logic           clk,
  input  logic           rst,
  wrapper_risc_if.slave  io
);
  localparam logic [5:0] OP_ADD  = 6'h00, OP_COMP = 6'h01, OP_AND  = 6'h02,
                         OP_XOR  = 6'h03, OP_ADDI = 6'h04, OP_SHLL = 6'h05,
                         OP_SHRL = 6'h06, OP_SHRA = 6'h07, OP_LW   = 6'h08,
                         OP_SW   = 6'h09, OP_B    = 6'h0A, OP_BZ   = 6'h0B,
                         OP_BNZ  = 6'h0C, OP_BLTZ = 6'h0D, OP_HALT = 6'h0E;

  logic [5:0]  pc;
  logic        halted;
  logic [31:0] regs [32];
  logic [31:0] ram  [64];

  // Accumulate 100..1, store/reload through RAM[0], then shift the sum left by 8.
  function automatic logic [31:0] rom_word(input logic [5:0] a);
    case (a)
      6'd0:    rom_word = {OP_ADDI, 5'd2, 5'd0, 16'd100};
      6'd1:    rom_word = {OP_ADD,  5'd1, 5'd2, 16'd0};
      6'd2:    rom_word = {OP_ADDI, 5'd2, 5'd0, 16'hFFFF};
      6'd3:    rom_word = {OP_BNZ,  5'd2, 5'd0, 16'd1};
      6'd4:    rom_word = {OP_SW,   5'd0, 5'd1, 16'd0};
      6'd5:    rom_word = {OP_LW,   5'd0, 5'd3, 16'd0};
      6'd6:    rom_word = {OP_SHLL, 5'd3, 5'd0, 16'd8};
      6'd7:    rom_word = {OP_XOR,  5'd1, 5'd1, 16'd0};
      6'd8:    rom_word = {OP_ADD,  5'd1, 5'd3, 16'd0};
      6'd9:    rom_word = {OP_HALT, 26'd0};
      default: rom_word = 32'hFC00_0000;
    endcase
  endfunction

  logic [31:0] instr;
  assign instr = rom_word(pc);

  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic [31:0] a, b, simm, reg_wd;
  logic [5:0]  ea, pc_nxt;
  logic        reg_we, ram_we, halt_op;
  logic [4:0]  reg_wa;

  assign op   = instr[31:26];
  assign rs   = instr[25:21];
  assign rt   = instr[20:16];
  assign imm  = instr[15:0];
  assign simm = {{16{imm[15]}}, imm};
  assign a    = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign b    = (rt == 5'd0) ? 32'd0 : regs[rt];
  // RAM is 64 words, so only the low 6 bits of the effective address matter.
  assign ea   = a[5:0] + imm[5:0];

  always_comb begin
    reg_we  = 1'b0;
    reg_wa  = rs;
    reg_wd  = 32'd0;
    ram_we  = 1'b0;
    halt_op = 1'b0;
    pc_nxt  = pc + 6'd1;
    case (op)
      OP_ADD:  begin reg_we = 1'b1; reg_wd = a + b;                           end
      OP_COMP: begin reg_we = 1'b1; reg_wd = ~b + 32'd1;                      end
      OP_AND:  begin reg_we = 1'b1; reg_wd = a & b;                           end
      OP_XOR:  begin reg_we = 1'b1; reg_wd = a ^ b;                           end
      OP_ADDI: begin reg_we = 1'b1; reg_wd = a + simm;                        end
      OP_SHLL: begin reg_we = 1'b1; reg_wd = a << imm[4:0];                   end
      OP_SHRL: begin reg_we = 1'b1; reg_wd = a >> imm[4:0];                   end
      OP_SHRA: begin reg_we = 1'b1; reg_wd = $unsigned($signed(a) >>> imm[4:0]); end
      OP_LW:   begin reg_we = 1'b1; reg_wa = rt; reg_wd = ram[ea];            end
      OP_SW:   ram_we = 1'b1;
      OP_B:    pc_nxt = imm[5:0];
      OP_BZ:   if (a == 32'd0) pc_nxt = imm[5:0];
      OP_BNZ:  if (a != 32'd0) pc_nxt = imm[5:0];
      OP_BLTZ: if (a[31])      pc_nxt = imm[5:0];
      OP_HALT: halt_op = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc     <= 6'd0;
      halted <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      for (int i = 0; i < 64; i++) ram[i]  <= 32'd0;
    end else if (!halted) begin
      if (halt_op) halted <= 1'b1;
      else         pc     <= pc_nxt;
      if (reg_we && reg_wa != 5'd0) regs[reg_wa] <= reg_wd;
      if (ram_we) ram[ea] <= b;
    end
  end

  assign io.out = io.button ? regs[1][31:16] : regs[1][15:0];
endmodule

// File: tb/tb_wrapper_risc.sv
// Bench for wrapper_risc: directed vector table, halt/reset sequences, an
// alternate-ROM ISA program and randomized runs against an ISA-level model.
module tb_wrapper_risc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  wrapper_risc_if io ();

  wrapper_risc dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- ISA-level reference model ----------------
  logic [31:0] m_rom [64];
  logic [31:0] m_r   [32];
  logic [31:0] m_ram [64];
  logic [5:0]  m_pc;
  bit          m_halt;

  function automatic logic [31:0] enc(input int op, input int rs, input int rt, input int imm);
    logic [31:0] w;
    w = 32'(op) << 26 | 32'(rs & 31) << 21 | 32'(rt & 31) << 16 | 32'(imm & 16'hFFFF);
    return w;
  endfunction

  task automatic load_default_rom();
    for (int i = 0; i < 64; i++) m_rom[i] = 32'hFC00_0000;
    m_rom[0] = enc(4, 2, 0, 100);
    m_rom[1] = enc(0, 1, 2, 0);
    m_rom[2] = enc(4, 2, 0, -1);
    m_rom[3] = enc(12, 2, 0, 1);
    m_rom[4] = enc(9, 0, 1, 0);
    m_rom[5] = enc(8, 0, 3, 0);
    m_rom[6] = enc(5, 3, 0, 8);
    m_rom[7] = enc(3, 1, 1, 0);
    m_rom[8] = enc(0, 1, 3, 0);
    m_rom[9] = enc(14, 0, 0, 0);
  endtask

  task automatic m_reset();
    m_pc = 0; m_halt = 0;
    for (int i = 0; i < 32; i++) m_r[i] = 0;
    for (int i = 0; i < 64; i++) m_ram[i] = 0;
  endtask

  task automatic m_write(input int idx, input logic [31:0] v);
    if (idx != 0) m_r[idx] = v;
  endtask

  task automatic m_step();
    logic [31:0] w, x, y, s;
    int op, rs, rt, sh, addr;
    logic [5:0] nxt;
    if (m_halt) return;
    w  = m_rom[m_pc];
    op = int'(w[31:26]); rs = int'(w[25:21]); rt = int'(w[20:16]);
    x  = m_r[rs]; y = m_r[rt];
    s  = {{16{w[15]}}, w[15:0]};
    sh = int'(w[4:0]);
    addr = int'((x + s) % 64);
    nxt = m_pc + 6'd1;
    case (op)
      0:  m_write(rs, x + y);
      1:  m_write(rs, 32'd0 - y);
      2:  m_write(rs, x & y);
      3:  m_write(rs, x ^ y);
      4:  m_write(rs, x + s);
      5:  m_write(rs, x << sh);
      6:  m_write(rs, x >> sh);
      7:  m_write(rs, $unsigned($signed(x) >>> sh));
      8:  m_write(rt, m_ram[addr]);
      9:  m_ram[addr] = y;
      10: nxt = w[5:0];
      11: if (x == 0)    nxt = w[5:0];
      12: if (x != 0)    nxt = w[5:0];
      13: if (x[31])     nxt = w[5:0];
      14: m_halt = 1;
      default: ;
    endcase
    if (!m_halt) m_pc = nxt;
  endtask

  function automatic logic [15:0] m_out(input logic btn);
    return btn ? m_r[1][31:16] : m_r[1][15:0];
  endfunction

  // ---------------- drive helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    m_reset();
    rst = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      m_step();
    end
  endtask

  typedef struct {
    int          cycles;
    logic        btn;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{0,   1'b0, 16'h0000};
    vecs[1]  = '{0,   1'b1, 16'h0000};
    vecs[2]  = '{2,   1'b0, 16'h0064};
    vecs[3]  = '{5,   1'b0, 16'h00C7};
    vecs[4]  = '{303, 1'b0, 16'h13BA};
    vecs[5]  = '{305, 1'b0, 16'h0000};
    vecs[6]  = '{306, 1'b0, 16'hBA00};
    vecs[7]  = '{306, 1'b1, 16'h0013};
    vecs[8]  = '{320, 1'b0, 16'hBA00};
    vecs[9]  = '{320, 1'b1, 16'h0013};
    vecs[10] = '{506, 1'b1, 16'h0013};

    io.button = 1'b0;
    load_default_rom();
    m_reset();

    // Table of (edges after reset, button, display value).
    for (int v = 0; v < 11; v++) begin
      io.button = 1'b0;
      do_reset();
      run(vecs[v].cycles);
      io.button = vecs[v].btn;
      #1;
      chk($sformatf("vec%0d_out", v), 32'(io.out), 32'(vecs[v].exp));
    end

    // Halt hold: pc, RAM[0] and display stay frozen for 200 extra edges.
    io.button = 1'b0;
    do_reset();
    run(306);
    chk("halt_pc_at_306", 32'(dut.pc), 32'd9);
    run(200);
    chk("halt_pc_held", 32'(dut.pc), 32'd9);
    chk("halt_flag", 32'(dut.halted), 32'd1);
    chk("halt_ram0", dut.ram[0], 32'h0000_13BA);
    chk("halt_out_lo", 32'(io.out), 32'h0000_BA00);
    io.button = 1'b1;
    #1;
    chk("halt_out_hi_nowait", 32'(io.out), 32'h0000_0013);

    // Reset mid-run at cycle 150, then the program reruns to completion.
    io.button = 1'b0;
    do_reset();
    run(150);
    rst = 1'b0;
    tick();
    m_reset();
    chk("midrst_out", 32'(io.out), 32'h0);
    chk("midrst_pc", 32'(dut.pc), 32'h0);
    chk("midrst_ram0", dut.ram[0], 32'h0);
    rst = 1'b1;
    run(320);
    chk("rerun_out_lo", 32'(io.out), 32'h0000_BA00);
    io.button = 1'b1;
    #1;
    chk("rerun_out_hi", 32'(io.out), 32'h0000_0013);

    // ISA directed program, fed by overriding the fetched instruction.
    for (int i = 0; i < 64; i++) m_rom[i] = 32'hFC00_0000;
    m_rom[0]  = enc(4, 4, 0, 5);        // r4 = 5
    m_rom[1]  = enc(1, 1, 4, 0);        // r1 = -r4
    m_rom[2]  = enc(3, 1, 1, 0);
    m_rom[3]  = enc(4, 1, 0, 1);
    m_rom[4]  = enc(5, 1, 0, 31);       // r1 = 0x80000000
    m_rom[5]  = enc(7, 1, 0, 4);
    m_rom[6]  = enc(5, 1, 0, 4);
    m_rom[7]  = enc(6, 1, 0, 4);
    m_rom[8]  = enc(4, 0, 0, 7);        // write to r0 must be dropped
    m_rom[9]  = enc(0, 1, 0, 0);
    m_rom[10] = enc(4, 6, 0, -1);
    m_rom[11] = enc(13, 6, 0, 13);      // taken: skips address 12
    m_rom[12] = enc(4, 1, 0, 1);
    m_rom[13] = enc(4, 1, 0, 2);
    m_rom[14] = enc(14, 0, 0, 0);
    io.button = 1'b0;
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      logic [31:0] exp_r1;
      bit          fixed;
      force dut.instr = m_rom[m_pc];
      tick();
      m_step();
      fixed = 1'b1;
      case (k)
        2:       exp_r1 = 32'hFFFF_FFFB;
        6:       exp_r1 = 32'hF800_0000;
        8:       exp_r1 = 32'h0800_0000;
        10:      exp_r1 = 32'h0800_0000;
        14:      exp_r1 = 32'h0800_0002;
        18:      exp_r1 = 32'h0800_0002;
        default: begin exp_r1 = 32'h0; fixed = 1'b0; end
      endcase
      io.button = 1'b0; #1;
      chk($sformatf("isa_model_lo_k%0d", k), 32'(io.out), 32'(m_out(1'b0)));
      if (fixed) chk($sformatf("isa_const_lo_k%0d", k), 32'(io.out), 32'(exp_r1[15:0]));
      io.button = 1'b1; #1;
      chk($sformatf("isa_model_hi_k%0d", k), 32'(io.out), 32'(m_out(1'b1)));
      if (fixed) chk($sformatf("isa_const_hi_k%0d", k), 32'(io.out), 32'(exp_r1[31:16]));
    end
    chk("isa_r0_zero", dut.regs[0], 32'h0);
    release dut.instr;
    load_default_rom();

    // Randomized button toggling and sporadic resets against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      io.button = 1'($urandom);
      rst = ($urandom_range(0, 299) != 0);
      tick();
      if (rst) m_step();
      else     m_reset();
      chk($sformatf("rand_c%0d", c), 32'(io.out), 32'(m_out(io.button)));
      io.button = ~io.button;
      #1;
      chk($sformatf("rand_flip_c%0d", c), 32'(io.out), 32'(m_out(io.button)));
    end
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
